// File: rtl/mult_seq_ctrl_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(WIDTH - 1);

    // state   | meaning
    // IDLE    | waiting for start; adder idle
    // NEG_A   | negate multiplicand magnitude through the adder
    // NEG_B   | negate multiplier magnitude through the adder
    // ITER    | one radix-2 shift-add step per cycle, WIDTH cycles
    // NEGP_LO | negate low product word, capture carry
    // NEGP_HI | negate high product word using captured carry
    // DONE    | product valid, done pulse
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        NEG_A   = 3'd1,
        NEG_B   = 3'd2,
        ITER    = 3'd3,
        NEGP_LO = 3'd4,
        NEGP_HI = 3'd5,
        DONE    = 3'd6
    } state_t;

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Handshake, operand/product and shared-adder signals of the multiplier.
interface mult_seq_ctrl_if
    import mult_pkg::*;
();
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] prod_hi;
    logic [WIDTH-1:0] prod_lo;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_s;
    logic             add_cout;

    // Execute-stage side: control unit plus the external adder.
    modport master (
        output start, is_signed, op_a, op_b, add_s, add_cout,
        input  busy, done, prod_hi, prod_lo, add_a, add_b, add_cin
    );

    // Sequencer side.
    modport slave (
        input  start, is_signed, op_a, op_b, add_s, add_cout,
        output busy, done, prod_hi, prod_lo, add_a, add_b, add_cin
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// 32x32 -> 64 multiplier sequencer time-sharing one external adder.
// Signed operands are reduced to magnitudes, multiplied unsigned, and the
// product is negated afterwards when the operand signs differ.
module mult_seq_ctrl
    import mult_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    mult_seq_ctrl_if.slave  bus
);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_m, w_m_nxt;
    logic [WIDTH-1:0] r_p_hi, w_p_hi_nxt;
    logic [WIDTH-1:0] r_p_lo, w_p_lo_nxt;
    logic             r_neg_res, w_neg_res_nxt;
    logic             r_neg_b, w_neg_b_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_c, w_c_nxt;
    logic [WIDTH-1:0] r_prod_hi, r_prod_lo;
    logic [WIDTH-1:0] w_add_a, w_add_b;
    logic             w_add_cin;
    logic             w_load_prod;

    // Next-state, datapath next values and adder operand selection.
    always_comb begin
        w_state_nxt   = r_state;
        w_m_nxt       = r_m;
        w_p_hi_nxt    = r_p_hi;
        w_p_lo_nxt    = r_p_lo;
        w_neg_res_nxt = r_neg_res;
        w_neg_b_nxt   = r_neg_b;
        w_cnt_nxt     = r_cnt;
        w_c_nxt       = r_c;
        w_add_a       = '0;
        w_add_b       = '0;
        w_add_cin     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_m_nxt       = bus.op_a;
                    w_p_lo_nxt    = bus.op_b;
                    w_p_hi_nxt    = '0;
                    w_cnt_nxt     = '0;
                    w_neg_res_nxt = bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                    w_neg_b_nxt   = bus.is_signed & bus.op_b[WIDTH-1];
                    if (bus.is_signed & bus.op_a[WIDTH-1])
                        w_state_nxt = NEG_A;
                    else if (bus.is_signed & bus.op_b[WIDTH-1])
                        w_state_nxt = NEG_B;
                    else
                        w_state_nxt = ITER;
                end
            end
            NEG_A: begin
                w_add_a     = ~r_m;
                w_add_cin   = 1'b1;
                w_m_nxt     = bus.add_s;
                w_state_nxt = r_neg_b ? NEG_B : ITER;
            end
            NEG_B: begin
                w_add_a     = ~r_p_lo;
                w_add_cin   = 1'b1;
                w_p_lo_nxt  = bus.add_s;
                w_state_nxt = ITER;
            end
            ITER: begin
                w_add_a   = r_p_hi;
                w_add_b   = r_p_lo[0] ? r_m : '0;
                {w_p_hi_nxt, w_p_lo_nxt} = {bus.add_cout, bus.add_s, r_p_lo[WIDTH-1:1]};
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == ITER_LAST)
                    w_state_nxt = r_neg_res ? NEGP_LO : DONE;
            end
            NEGP_LO: begin
                w_add_a     = ~r_p_lo;
                w_add_cin   = 1'b1;
                w_p_lo_nxt  = bus.add_s;
                w_c_nxt     = bus.add_cout;
                w_state_nxt = NEGP_HI;
            end
            NEGP_HI: begin
                w_add_a     = ~r_p_hi;
                w_add_cin   = r_c;
                w_p_hi_nxt  = bus.add_s;
                w_state_nxt = DONE;
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Product is captured on the edge that enters DONE so it is valid with done.
    assign w_load_prod = (w_state_nxt == DONE) && (r_state != DONE);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_m       <= '0;
            r_p_hi    <= '0;
            r_p_lo    <= '0;
            r_neg_res <= 1'b0;
            r_neg_b   <= 1'b0;
            r_cnt     <= '0;
            r_c       <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_m       <= w_m_nxt;
            r_p_hi    <= w_p_hi_nxt;
            r_p_lo    <= w_p_lo_nxt;
            r_neg_res <= w_neg_res_nxt;
            r_neg_b   <= w_neg_b_nxt;
            r_cnt     <= w_cnt_nxt;
            r_c       <= w_c_nxt;
        end
    end

    // Product output registers, held until the next result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod_hi <= '0;
            r_prod_lo <= '0;
        end else if (w_load_prod) begin
            r_prod_hi <= w_p_hi_nxt;
            r_prod_lo <= w_p_lo_nxt;
        end
    end

    assign bus.busy    = (r_state != IDLE);
    assign bus.done    = (r_state == DONE);
    assign bus.prod_hi = r_prod_hi;
    assign bus.prod_lo = r_prod_lo;
    assign bus.add_a   = w_add_a;
    assign bus.add_b   = w_add_b;
    assign bus.add_cin = w_add_cin;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl with a behavioural 32-bit adder.
module tb_mult_seq_ctrl;
    import mult_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_bad;

    mult_seq_ctrl_if ifc ();

    mult_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    assign {ifc.add_cout, ifc.add_s} = {1'b0, ifc.add_a} + {1'b0, ifc.add_b}
                                     + {{WIDTH{1'b0}}, ifc.add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Accept one operation and wait (bounded) for done; cycle 1 is the
    // cycle right after the accepting edge.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [63:0] exp_p, input int exp_lat);
        int cyc;
        @(negedge clk);
        ifc.op_a      = a;
        ifc.op_b      = b;
        ifc.is_signed = sgn;
        ifc.start     = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        cyc = 1;
        chk({tag, "_busy"}, 64'(ifc.busy), 64'd1);
        while (!ifc.done && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
        chk({tag, "_prod"}, {ifc.prod_hi, ifc.prod_lo}, exp_p);
        @(negedge clk);
        chk({tag, "_idle"}, {62'd0, ifc.busy, ifc.done}, 64'd0);
        chk({tag, "_held"}, {ifc.prod_hi, ifc.prod_lo}, exp_p);
        chk({tag, "_adder_idle"}, {ifc.add_a, ifc.add_b[30:0], ifc.add_cin}, 64'd0);
    endtask

    initial begin
        int   cyc;
        int   n_done;
        int   done_cyc;
        logic busy37;
        n_chk = 0;
        n_bad = 0;
        rst_n = 1'b0;
        ifc.start     = 1'b0;
        ifc.is_signed = 1'b0;
        ifc.op_a      = '0;
        ifc.op_b      = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy_done", {62'd0, ifc.busy, ifc.done}, 64'd0);
        chk("rst_prod", {ifc.prod_hi, ifc.prod_lo}, 64'd0);
        chk("rst_adder", {ifc.add_a, ifc.add_b[30:0], ifc.add_cin}, 64'd0);
        rst_n = 1'b1;

        run_op("u_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 33);
        run_op("s_neg3x7", 32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 36);
        run_op("s_minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 35);
        run_op("s_0xneg5", 32'd0, 32'hFFFF_FFFB, 1'b1, 64'd0, 36);
        run_op("s_7xneg3", 32'd7, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 36);
        run_op("u_min_sq", 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, 33);

        // Stray starts at cycles 5 and 34 must be ignored.
        @(negedge clk);
        ifc.op_a      = 32'hFFFF_FFFD;
        ifc.op_b      = 32'd7;
        ifc.is_signed = 1'b1;
        ifc.start     = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        n_done    = 0;
        done_cyc  = 0;
        busy37    = 1'b1;
        for (cyc = 1; cyc <= 40; cyc++) begin
            if (ifc.done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (cyc == 37) busy37 = ifc.busy;
            ifc.start = (cyc == 5 || cyc == 34);
            if (ifc.start) begin
                ifc.op_a      = 32'd17;
                ifc.op_b      = 32'd3;
                ifc.is_signed = 1'b0;
            end
            @(negedge clk);
        end
        ifc.start = 1'b0;
        chk("hs_done_count", 64'(n_done), 64'd1);
        chk("hs_done_cycle", 64'(done_cyc), 64'd36);
        chk("hs_busy_after_done", 64'(busy37), 64'd0);
        chk("hs_prod", {ifc.prod_hi, ifc.prod_lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        // Reset in the middle of an operation.
        @(negedge clk);
        ifc.op_a      = 32'hFFFF_FFFF;
        ifc.op_b      = 32'hFFFF_FFFF;
        ifc.is_signed = 1'b0;
        ifc.start     = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_busy_before", 64'(ifc.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy_done", {62'd0, ifc.busy, ifc.done}, 64'd0);
        chk("mid_rst_prod", {ifc.prod_hi, ifc.prod_lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        n_done = 0;
        while (cyc < 40) begin
            if (ifc.done) n_done++;
            @(negedge clk);
            cyc++;
        end
        chk("mid_rst_no_done", 64'(n_done), 64'd0);
        run_op("u_6x7", 32'd6, 32'd7, 1'b0, 64'd42, 33);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
